// File: rtl/seg15_pkg.sv
// Shared 15-segment encoding and digit-select constants, used by the bcd_seg
// encoder and by the scan-capture decoder. Segments are active-low.
package seg15_pkg;

  localparam logic [14:0] SEG_0     = 15'h7FC0;
  localparam logic [14:0] SEG_1     = 15'h7FF9;
  localparam logic [14:0] SEG_2     = 15'h7DA4;
  localparam logic [14:0] SEG_3     = 15'h7DB0;
  localparam logic [14:0] SEG_4     = 15'h7D99;
  localparam logic [14:0] SEG_5     = 15'h7D92;
  localparam logic [14:0] SEG_6     = 15'h7D82;
  localparam logic [14:0] SEG_7     = 15'h7FF8;
  localparam logic [14:0] SEG_8     = 15'h7D80;
  localparam logic [14:0] SEG_9     = 15'h7D90;
  localparam logic [14:0] SEG_BLANK = 15'h7FFF;

  localparam logic [3:0] DIG_SEL0 = 4'b1110;
  localparam logic [3:0] DIG_SEL1 = 4'b1101;
  localparam logic [3:0] DIG_SEL2 = 4'b1011;
  localparam logic [3:0] DIG_SEL3 = 4'b0111;

  typedef struct packed {
    logic       one;  // exactly one digit enable is active
    logic [1:0] idx;  // index of that digit
  } dig_sel_t;

  function automatic dig_sel_t sel_decode(input logic [3:0] wh);
    dig_sel_t s;
    s = '{one: 1'b0, idx: 2'd0};
    case (wh)
      DIG_SEL0: s = '{one: 1'b1, idx: 2'd0};
      DIG_SEL1: s = '{one: 1'b1, idx: 2'd1};
      DIG_SEL2: s = '{one: 1'b1, idx: 2'd2};
      DIG_SEL3: s = '{one: 1'b1, idx: 2'd3};
      default:  s = '{one: 1'b0, idx: 2'd0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg15_decode.sv
// Combinational 15-segment to BCD decoder; flags numerals and the blank pattern.
module seg15_decode
  import seg15_pkg::*;
(
  input  logic [14:0] pattern,
  output logic [3:0]  bcd,
  output logic        is_num,
  output logic        is_blank
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    bcd      = 4'd0;
    is_num   = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        is_num   = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_num = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive-side monitor for the multiplexed 15-segment bus: filters scan
// transitions, decodes stable digits and rebuilds the 4-digit displayed value.
module seg_scan_capture
  import seg15_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] display,
  input  logic [3:0]  wh_light,
  input  logic        err_clr,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit_valid,
  output logic [15:0] frame_value,
  output logic        frame_done,
  output logic [1:0]  err,
  output logic        stale
);

  localparam int              TW      = $clog2(TIMEOUT);
  localparam logic [7:0]      CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]   TO_MAX  = TW'(TIMEOUT - 1);

  logic [3:0]       samp_wh;
  logic [14:0]      samp_disp;
  logic [7:0]       stab_cnt;
  logic             captured;
  logic [3:0]       seen;
  logic [TW-1:0]    to_cnt;
  logic [3:0][3:0]  digit_q;

  logic [3:0]       bcd;
  logic             is_num;
  logic             is_blank;
  dig_sel_t         dsel;
  logic             same;
  logic             cap_fire;
  logic             cap_num;
  logic             cap_blank;
  logic             cap_bad;
  logic             cap_multi;
  logic             digit_hit;
  logic [3:0]       hit_mask;
  logic [3:0]       seen_nx;
  logic [3:0]       valid_nx;
  logic [3:0][3:0]  digits_nx;
  logic             frame_hit;

  seg15_decode u_decode (
    .pattern  (samp_disp),
    .bcd      (bcd),
    .is_num   (is_num),
    .is_blank (is_blank)
  );

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];

  always_comb begin
    same      = ({wh_light, display} == {samp_wh, samp_disp});
    dsel      = sel_decode(samp_wh);
    cap_fire  = (stab_cnt == CNT_MAX) && !captured;
    cap_num   = cap_fire && dsel.one && is_num;
    cap_blank = cap_fire && dsel.one && is_blank;
    cap_bad   = cap_fire && dsel.one && !is_num && !is_blank;
    cap_multi = cap_fire && !dsel.one && (samp_wh != 4'hF);
    digit_hit = cap_num || cap_blank;
    hit_mask  = 4'b0001 << dsel.idx;

    digits_nx = digit_q;
    valid_nx  = digit_valid;
    seen_nx   = seen;
    // Timeout invalidates everything; a capture in the same cycle still lands.
    if (to_cnt == TO_MAX) valid_nx = 4'h0;
    if (cap_num) begin
      digits_nx[dsel.idx] = bcd;
      valid_nx[dsel.idx]  = 1'b1;
      seen_nx             = seen | hit_mask;
    end
    if (cap_blank) begin
      valid_nx[dsel.idx] = 1'b0;
      seen_nx            = seen | hit_mask;
    end
    frame_hit = (seen_nx == 4'hF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_wh     <= 4'hF;
      samp_disp   <= 15'h7FFF;
      stab_cnt    <= 8'd0;
      captured    <= 1'b0;
      seen        <= 4'h0;
      to_cnt      <= '0;
      digit_q     <= '0;
      digit_valid <= 4'h0;
      frame_value <= 16'h0000;
      frame_done  <= 1'b0;
      err         <= 2'b00;
      stale       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      samp_wh   <= wh_light;
      samp_disp <= display;
      if (same) begin
        stab_cnt <= (stab_cnt == CNT_MAX) ? stab_cnt : stab_cnt + 8'd1;
        captured <= captured | cap_fire;
      end else begin
        stab_cnt <= 8'd0;
        captured <= 1'b0;
      end

      digit_q     <= digits_nx;
      digit_valid <= valid_nx;

      if (frame_hit) begin
        frame_done  <= 1'b1;
        frame_value <= digits_nx;
        seen        <= 4'h0;
      end else begin
        frame_done  <= 1'b0;
        seen        <= seen_nx;
      end

      // Set beats clear when both happen in one cycle.
      err <= (err & {2{~err_clr}}) | {cap_multi, cap_bad};

      if (digit_hit) begin
        to_cnt <= '0;
        stale  <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TW'(1);
      end else begin
        stale  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: latency, framing, glitch rejection,
// error flags, blank/stale handling and asynchronous reset mid-dwell.
module tb_seg_scan_capture;
  import seg15_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] display;
  logic [3:0]  wh_light;
  logic        err_clr;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic [3:0]  digit_valid;
  logic [15:0] frame_value;
  logic        frame_done;
  logic [1:0]  err;
  logic        stale;

  int checks = 0;
  int errors = 0;

  seg_scan_capture #(.STABLE_CYCLES(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .display     (display),
    .wh_light    (wh_light),
    .err_clr     (err_clr),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .digit_valid (digit_valid),
    .frame_value (frame_value),
    .frame_done  (frame_done),
    .err         (err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [14:0] seg_tab [10];
  logic [3:0]  sel_tab [4];
  int          fd_cnt;
  int          fd_at;
  int          bad5;

  initial begin
    seg_tab = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
    sel_tab = '{DIG_SEL0, DIG_SEL1, DIG_SEL2, DIG_SEL3};
    rst_n    = 1'b0;
    wh_light = 4'hF;
    display  = SEG_BLANK;
    err_clr  = 1'b0;
    step(2);
    check("rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check("rst_valid",  digit_valid, 4'h0);
    check("rst_misc",   {frame_value, frame_done, err, stale}, 20'h0);
    rst_n = 1'b1;
    step(2);

    // 1: decode and latency
    wh_light = DIG_SEL2;
    display  = SEG_7;
    step(4);
    check("t1_before_digit2", digit2, 4'd0);
    check("t1_before_valid",  digit_valid, 4'h0);
    step(1);
    check("t1_digit2", digit2, 4'd7);
    check("t1_valid",  digit_valid, 4'b0100);
    step(3);
    check("t1_hold_digit2", digit2, 4'd7);
    check("t1_hold_fd",     frame_done, 1'b0);

    // 2: full frame with blanking gaps
    fd_cnt = 0;
    fd_at  = -1;
    for (int d = 0; d < 4; d++) begin
      wh_light = sel_tab[d];
      display  = seg_tab[d+1];
      for (int c = 1; c <= 10; c++) begin
        step(1);
        if (frame_done) begin
          fd_cnt++;
          fd_at = d * 100 + c;
        end
      end
      wh_light = 4'hF;
      display  = SEG_BLANK;
      for (int c = 1; c <= 3; c++) begin
        step(1);
        if (frame_done) fd_cnt++;
      end
    end
    check("t2_fd_count", fd_cnt, 1);
    check("t2_fd_when",  fd_at, 305);
    check("t2_frame",    frame_value, 16'h4321);
    check("t2_digits",   {digit3, digit2, digit1, digit0}, 16'h4321);
    check("t2_valid",    digit_valid, 4'hF);

    // 3: glitch rejection
    bad5     = 0;
    wh_light = DIG_SEL1;
    display  = SEG_5;
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (digit1 == 4'd5) bad5++;
    end
    display = SEG_8;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (digit1 == 4'd5) bad5++;
    end
    check("t3_no5",   bad5, 0);
    check("t3_digit1", digit1, 4'd8);
    check("t3_err",    err, 2'b00);

    // 4: error flags
    wh_light = DIG_SEL0;
    display  = 15'h0000;
    step(6);
    check("t4_err_bad",    err, 2'b01);
    check("t4_digit0",     digit0, 4'd1);
    check("t4_valid0",     digit_valid[0], 1'b1);
    wh_light = 4'b1100;
    display  = SEG_3;
    step(6);
    check("t4_err_multi",  err, 2'b11);
    check("t4_digits",     {digit3, digit2, digit1, digit0}, 16'h4381);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check("t4_err_clr",    err, 2'b00);

    // 5: blank capture then stale
    wh_light = DIG_SEL3;
    display  = SEG_BLANK;
    step(6);
    check("t5_blank_valid", digit_valid, 4'b0111);
    check("t5_blank_digit", digit3, 4'd4);
    wh_light = 4'hF;
    step(60);
    check("t5_not_stale", stale, 1'b0);
    step(10);
    check("t5_stale",       stale, 1'b1);
    check("t5_stale_valid", digit_valid, 4'h0);
    wh_light = DIG_SEL0;
    display  = SEG_9;
    step(6);
    check("t5_unstale",  stale, 1'b0);
    check("t5_digit0",   digit0, 4'd9);
    check("t5_valid",    digit_valid, 4'b0001);

    // 6: async reset during a dwell at count 2
    wh_light = DIG_SEL1;
    display  = SEG_6;
    step(3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    check("t6_rst_misc",   {digit_valid, frame_value, frame_done, err, stale}, 24'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4);
    check("t6_before",      {digit1, digit_valid}, 8'h00);
    step(1);
    check("t6_digit1",      digit1, 4'd6);
    check("t6_valid",       digit_valid, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side monitor for the multiplexed 15-segment display bus driven by the stopwatch/clock display path.
- Samples the scanned segment pattern and the active-low digit-enable lines, and filters out scan transitions.
- Decodes each stable pattern back to BCD and rebuilds the 4-digit value shown on the display.
- Used for on-chip self-check and for the verification bench that checks displayed time against counter state.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical samples required before a capture; legal range 2..255.
- TIMEOUT, 1048576: clock cycles without any capture before the display is declared stale; must be at least 2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- display, input, 15: segment pattern, same encoding as the bcd_seg output.
- wh_light, input, 4: digit enables, active-low; 4'b1110 selects digit 0 (in0), 4'b0111 selects digit 3.
- err_clr, input, 1: synchronous clear of the sticky error bits.
- digit0..digit3, output, 4 each: last decoded BCD value per digit.
- digit_valid, output, 4: per-digit flag meaning "holds a decoded numeral".
- frame_value, output, 16: {digit3,digit2,digit1,digit0} snapshot taken at frame completion.
- frame_done, output, 1: one-cycle pulse when all four digits have been captured since the previous pulse.
- err, output, 2: sticky error flags. Bit0 = undecodable pattern. Bit1 = more than one digit enabled during a stable sample.
- stale, output, 1: high when no capture has occurred for TIMEOUT cycles.

Behaviour:
- Reset (async, rst_n=0) values:
  - digit0..3 = 0, digit_valid = 0, frame_value = 0, frame_done = 0, err = 0, stale = 0.
  - Internal state cleared: sample register = {4'hF, 15'h7FFF}, stability count = 0, captured flag = 0, seen mask = 0, timeout count = 0.
- Input stage: {wh_light, display} is registered every cycle.
- Stability filter:
  - If the new sample equals the previous sample, the count increments, saturating at STABLE_CYCLES-1.
  - If the sample differs, the count goes to 0 and the captured flag clears.
- Capture condition: count == STABLE_CYCLES-1 and captured flag == 0. The captured flag is then set, so there is exactly one capture per dwell.
- Latency: with inputs held constant after a change, the outputs update on the (STABLE_CYCLES+1)th rising edge after the change; 5 edges at the default.
- Capture action, by wh_light value:
  - Exactly one bit low (index N):
    - display matches SEG_0..SEG_9: digitN <= value, digit_valid[N] <= 1, seen[N] <= 1.
    - display == SEG_BLANK: digit_valid[N] <= 0, seen[N] <= 1, digitN holds.
    - Any other pattern: err[0] <= 1, digitN and digit_valid[N] unchanged, seen[N] unchanged.
  - All ones (4'hF, blanking interval): no capture, no error, no state change.
  - Two or more bits low: err[1] <= 1, nothing else changes.
- Frame completion:
  - On the edge where seen becomes 4'hF, frame_done = 1 for one cycle.
  - In that same edge: frame_value <= the post-capture digit values, and seen <= 0.
  - A digit recaptured before the frame completes overwrites its value; seen is unaffected.
- Timeout:
  - The counter resets on every capture, including blank captures, and otherwise increments, saturating.
  - At count == TIMEOUT-1: stale <= 1 and digit_valid <= 0.
  - stale clears on the next capture.
  - seen is not cleared by timeout.
- Error bits:
  - err bits are sticky.
  - err_clr clears them synchronously.
  - If err_clr and a new error occur in the same cycle, the set wins.
- Reset mid-dwell: all state clears immediately. A capture requires a fresh full dwell after rst_n deasserts.

Decomposition:
- Shared package seg15_pkg holds:
  - constants SEG_0..SEG_9 and SEG_BLANK (15'h7FFF);
  - DIG_SEL0..DIG_SEL3 (4'b1110, 4'b1101, 4'b1011, 4'b0111).
  - bcd_seg switches to these constants, so encoder and decoder share one source of truth.
- One natural sub-module: seg15_decode, combinational.
  - Input: 15-bit pattern.
  - Outputs: bcd[3:0], is_num, is_blank.

Test Plan:
1. Decode and latency: wh_light=DIG_SEL2, display=SEG_7 held 8 cycles -> digit2=7 and digit_valid[2]=1 exactly 5 edges after the change. There is no further update during the dwell.
2. Full frame: cycle DIG_SEL0..3 with SEG_1, SEG_2, SEG_3, SEG_4, each held 10 cycles with a 4'hF gap between digits -> a single frame_done pulse after digit 3's capture, and frame_value=16'h4321.
3. Glitch rejection: hold DIG_SEL1/SEG_5 for 3 cycles, then SEG_8 for 10 cycles -> digit1=8. Value 5 is never captured and err=0.
4. Errors: stable DIG_SEL0 with pattern 15'h0000 -> err=2'b01, and digit0 is unchanged. Then stable wh_light=4'b1100 -> err=2'b11. Then pulse err_clr -> err=0.
5. Blank and stale (TIMEOUT=64 for this test): capture SEG_BLANK on digit 3 -> digit_valid[3]=0. Then hold wh_light=4'hF for 70 cycles -> stale=1 and digit_valid=0. The next valid capture clears stale.
6. Async reset during a dwell at count 2 -> all outputs are 0 immediately. With inputs unchanged after rst_n rises, the capture occurs 5 edges later.
